// File: rtl/egg_timer_countdown_ctrl.sv
// Egg timer MM:SS BCD countdown sequencer: load, run, pause/resume, 1 Hz decrement with borrow,
// expiry detection and a timed, blinking alarm.
module egg_timer_countdown_ctrl #(
    parameter int unsigned ALARM_SECS   = 10,
    parameter logic [3:0]  MAX_MIN_TENS = 4'd9
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_tick_1hz,
    input  logic       i_start_pause,
    input  logic       i_clear,
    input  logic       i_load,
    input  logic [3:0] i_load_min_tens,
    input  logic [3:0] i_load_min_ones,
    input  logic [3:0] i_load_sec_tens,
    input  logic [3:0] i_load_sec_ones,
    output logic [3:0] o_min_tens,
    output logic [3:0] o_min_ones,
    output logic [3:0] o_sec_tens,
    output logic [3:0] o_sec_ones,
    output logic       o_running,
    output logic       o_paused,
    output logic       o_done,
    output logic       o_alarm,
    output logic [2:0] o_state
);

    // state   | meaning
    // IDLE    | stopped, waiting for load / start
    // RUNNING | counting down once per tick
    // PAUSED  | count frozen, ticks ignored
    // ALARM   | count expired, alarm blinking for ALARM_SECS ticks
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_PAUSE = 3'd2;
    localparam logic [2:0] S_ALARM = 3'd3;
    localparam logic [7:0] ALARM_LAST = 8'(ALARM_SECS - 1);

    logic [2:0] r_state, w_state_nxt;
    logic [3:0] r_min_tens, r_min_ones, r_sec_tens, r_sec_ones;
    logic [7:0] r_alarm_cnt;
    logic       r_alarm, r_done;
    logic       w_is_zero, w_is_one, w_load_ok, w_dec, w_expire;

    function automatic logic [3:0] sat(input logic [3:0] d, input logic [3:0] mx);
        return (d > mx) ? mx : d;
    endfunction

    assign w_is_zero = ({r_min_tens, r_min_ones, r_sec_tens, r_sec_ones} == 16'h0000);
    assign w_is_one  = ({r_min_tens, r_min_ones, r_sec_tens, r_sec_ones} == 16'h0001);
    assign w_load_ok = i_load && (r_state == S_IDLE || r_state == S_PAUSE);
    // Pause beats a coincident tick; a zero count is never decremented.
    assign w_dec     = (r_state == S_RUN) && i_tick_1hz && !i_start_pause && !i_clear && !w_is_zero;

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_expire    = 1'b0;
        if (i_clear) begin
            w_state_nxt = S_IDLE;
        end else if (!w_load_ok) begin
            case (r_state)
                S_IDLE:  if (i_start_pause && !w_is_zero) w_state_nxt = S_RUN;
                S_RUN: begin
                    if (i_start_pause) begin
                        w_state_nxt = S_PAUSE;
                    end else if (i_tick_1hz && w_is_one) begin
                        w_state_nxt = S_ALARM;
                        w_expire    = 1'b1;
                    end
                end
                S_PAUSE: if (i_start_pause) w_state_nxt = w_is_zero ? S_IDLE : S_RUN;
                S_ALARM: begin
                    if (i_start_pause || (i_tick_1hz && r_alarm_cnt == ALARM_LAST))
                        w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_min_tens <= 4'd0;
            r_min_ones <= 4'd0;
            r_sec_tens <= 4'd0;
            r_sec_ones <= 4'd0;
        end else if (w_load_ok) begin
            r_min_tens <= sat(i_load_min_tens, MAX_MIN_TENS);
            r_min_ones <= sat(i_load_min_ones, 4'd9);
            r_sec_tens <= sat(i_load_sec_tens, 4'd5);
            r_sec_ones <= sat(i_load_sec_ones, 4'd9);
        end else if (w_dec) begin
            if (r_sec_ones != 4'd0) begin
                r_sec_ones <= r_sec_ones - 4'd1;
            end else begin
                r_sec_ones <= 4'd9;
                if (r_sec_tens != 4'd0) begin
                    r_sec_tens <= r_sec_tens - 4'd1;
                end else begin
                    r_sec_tens <= 4'd5;
                    if (r_min_ones != 4'd0) begin
                        r_min_ones <= r_min_ones - 4'd1;
                    end else begin
                        r_min_ones <= 4'd9;
                        r_min_tens <= r_min_tens - 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_alarm_cnt <= 8'd0;
            r_alarm     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_expire;
            if (w_expire) begin
                r_alarm     <= 1'b1;
                r_alarm_cnt <= 8'd0;
            end else if (r_state == S_ALARM) begin
                if (w_state_nxt != S_ALARM) begin
                    r_alarm     <= 1'b0;
                    r_alarm_cnt <= 8'd0;
                end else if (i_tick_1hz) begin
                    r_alarm     <= ~r_alarm;
                    r_alarm_cnt <= r_alarm_cnt + 8'd1;
                end
            end
        end
    end

    always_comb begin
        o_state    = r_state;
        o_running  = (r_state == S_RUN);
        o_paused   = (r_state == S_PAUSE);
        o_done     = r_done;
        o_alarm    = r_alarm;
        o_min_tens = r_min_tens;
        o_min_ones = r_min_ones;
        o_sec_tens = r_sec_tens;
        o_sec_ones = r_sec_ones;
    end

endmodule

// File: tb/tb_egg_timer_countdown_ctrl.sv
// Directed bench for the egg timer sequencer: count, borrow, pause, alarm timing and priorities.
module tb_egg_timer_countdown_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0, tick = 1'b0, sp = 1'b0, clr = 1'b0, ld = 1'b0;
    logic [3:0] ld_mt = 4'd0, ld_mo = 4'd0, ld_st = 4'd0, ld_so = 4'd0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, paused, done, alarm;
    logic [2:0] state;
    int         n_chk = 0;
    int         n_err = 0;

    egg_timer_countdown_ctrl #(.ALARM_SECS(10), .MAX_MIN_TENS(4'd9)) dut (
        .i_clk(clk), .i_reset(reset), .i_tick_1hz(tick), .i_start_pause(sp),
        .i_clear(clr), .i_load(ld),
        .i_load_min_tens(ld_mt), .i_load_min_ones(ld_mo),
        .i_load_sec_tens(ld_st), .i_load_sec_ones(ld_so),
        .o_min_tens(min_tens), .o_min_ones(min_ones),
        .o_sec_tens(sec_tens), .o_sec_ones(sec_ones),
        .o_running(running), .o_paused(paused), .o_done(done), .o_alarm(alarm),
        .o_state(state)
    );

    always #5 clk = ~clk;

    // One clock with the given pulses; sampling happens 1 ns after the edge.
    task automatic cyc(input logic p_sp, input logic p_tick, input logic p_clr, input logic p_ld);
        sp = p_sp; tick = p_tick; clr = p_clr; ld = p_ld;
        @(posedge clk);
        #1;
        sp = 1'b0; tick = 1'b0; clr = 1'b0; ld = 1'b0;
    endtask

    task automatic set_ld(input logic [15:0] v);
        {ld_mt, ld_mo, ld_st, ld_so} = v;
    endtask

    task automatic chk_cnt(input string tag, input logic [15:0] exp);
        n_chk++;
        assert ({min_tens, min_ones, sec_tens, sec_ones} === exp) else begin
            n_err++;
            $error("FAIL %s count observed=%h expected=%h", tag,
                   {min_tens, min_ones, sec_tens, sec_ones}, exp);
        end
    endtask

    // status = {state, running, paused, done, alarm}
    task automatic chk_st(input string tag, input logic [2:0] s, input logic r, input logic p,
                          input logic d, input logic a);
        n_chk++;
        assert ({state, running, paused, done, alarm} === {s, r, p, d, a}) else begin
            n_err++;
            $error("FAIL %s status observed=%b expected=%b", tag,
                   {state, running, paused, done, alarm}, {s, r, p, d, a});
        end
    endtask

    initial begin
        reset = 1'b1;
        cyc(0, 0, 0, 0);
        reset = 1'b0;
        chk_cnt("reset_cnt", 16'h0000);
        chk_st("reset_st", 3'd0, 0, 0, 0, 0);

        // start with 00:00 is ignored
        cyc(1, 0, 0, 0);
        chk_st("start_zero", 3'd0, 0, 0, 0, 0);

        // 01:00 countdown to expiry
        set_ld(16'h0100);
        cyc(0, 0, 0, 1);
        chk_cnt("load_0100", 16'h0100);
        chk_st("load_idle", 3'd0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk_st("start_run", 3'd1, 1, 0, 0, 0);
        chk_cnt("start_nodec", 16'h0100);
        cyc(0, 1, 0, 0);
        chk_cnt("tick_0059", 16'h0059);
        for (int i = 0; i < 58; i++) cyc(0, 1, 0, 0);
        chk_cnt("tick_0001", 16'h0001);
        chk_st("still_run", 3'd1, 1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        chk_cnt("expire_cnt", 16'h0000);
        chk_st("expire_st", 3'd3, 0, 0, 1, 1);
        cyc(0, 0, 0, 0);
        chk_st("done_pulse_end", 3'd3, 0, 0, 0, 1);

        // alarm blinks for 10 ticks, then returns to IDLE
        for (int i = 1; i <= 9; i++) begin
            cyc(0, 1, 0, 0);
            chk_st($sformatf("alarm_tick%0d", i), 3'd3, 0, 0, 0, ~i[0]);
        end
        chk_cnt("alarm_digits", 16'h0000);
        cyc(0, 1, 0, 0);
        chk_st("alarm_timeout", 3'd0, 0, 0, 0, 0);

        // reset mid-run at 03:27
        set_ld(16'h0327);
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        chk_st("run_0327", 3'd1, 1, 0, 0, 0);
        reset = 1'b1;
        cyc(0, 0, 0, 0);
        reset = 1'b0;
        chk_cnt("rst_mid_cnt", 16'h0000);
        chk_st("rst_mid_st", 3'd0, 0, 0, 0, 0);

        // triple borrow, then saturating load while paused
        set_ld(16'h1000);
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        chk_cnt("borrow_0959", 16'h0959);
        cyc(1, 0, 0, 0);
        chk_st("pause_0959", 3'd2, 0, 1, 0, 0);
        set_ld(16'hFF99);
        cyc(0, 0, 0, 1);
        chk_cnt("sat_load", 16'h9959);
        chk_st("load_paused", 3'd2, 0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        chk_cnt("clear_cnt", 16'h0000);
        chk_st("clear_st", 3'd0, 0, 0, 0, 0);

        // pause beats tick; paused ignores ticks; resume with tick does not decrement
        set_ld(16'h0005);
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        chk_st("pause_vs_tick", 3'd2, 0, 1, 0, 0);
        chk_cnt("pause_vs_tick_cnt", 16'h0005);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
        chk_cnt("paused_ticks", 16'h0005);
        cyc(1, 1, 0, 0);
        chk_st("resume", 3'd1, 1, 0, 0, 0);
        chk_cnt("resume_nodec", 16'h0005);
        cyc(0, 1, 0, 0);
        chk_cnt("run_0004", 16'h0004);

        // load ignored while running
        set_ld(16'h1234);
        cyc(0, 0, 0, 1);
        chk_cnt("load_in_run", 16'h0004);
        chk_st("load_in_run_st", 3'd1, 1, 0, 0, 0);

        // expiry then acknowledge at alarm tick 3
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
        chk_st("expire2", 3'd3, 0, 0, 1, 1);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        chk_st("alarm2_tick2", 3'd3, 0, 0, 0, 1);
        cyc(1, 1, 0, 0);
        chk_st("alarm_ack", 3'd0, 0, 0, 0, 0);

        // resume from paused 00:00 goes to IDLE
        set_ld(16'h0030);
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        set_ld(16'h0000);
        cyc(0, 0, 0, 1);
        chk_st("paused_zero", 3'd2, 0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        chk_st("resume_zero", 3'd0, 0, 0, 0, 0);

        // clear beats load
        set_ld(16'h0500);
        cyc(0, 0, 0, 1);
        chk_cnt("load_0500", 16'h0500);
        set_ld(16'h0700);
        cyc(0, 0, 1, 1);
        chk_cnt("clear_load", 16'h0000);
        chk_st("clear_load_st", 3'd0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
